// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: shared definitions for the stream_mux_rr slice.
//   MODE_RR / MODE_FIXED : values of prio_mode
//   lock_state_t         : packet-lock FSM state encoding
//   sel_w()              : source-index width, max(1, $clog2(n))
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: N producer streams in, one consumer stream out.
//   prio_mode             : 0 round-robin, 1 fixed priority
//   in_valid/in_data/in_last/in_ready : per-channel producer handshake
//   out_valid/out_data/out_last/out_src/out_ready : consumer handshake
//   dbg_state/dbg_rr_ptr/dbg_lock_ch  : internal state visibility
//
// Handshake: a beat moves when valid && ready are both high at a rising
// clock edge. valid never depends on ready; ready may depend on valid.
// Once raised, the producer side is free to change valid/data each
// cycle (the mux re-arbitrates every cycle it can load).
//
// Modports: master = the environment (producers + consumer),
//           slave  = the multiplexer.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = sel_w(N_IN)
) ();

  logic                  prio_mode;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_last;
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_src;
  logic                  out_ready;
  lock_state_t           dbg_state;
  logic [SEL_W-1:0]      dbg_rr_ptr;
  logic [SEL_W-1:0]      dbg_lock_ch;

  modport master (
    output prio_mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src,
           dbg_state, dbg_rr_ptr, dbg_lock_ch
  );

  modport slave (
    input  prio_mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src,
           dbg_state, dbg_rr_ptr, dbg_lock_ch
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational request arbiter.
//   req        : per-channel requests
//   ptr        : first index searched in round-robin mode
//   fixed      : 1 = lowest requesting index wins, ptr ignored
//   gnt_onehot : one-hot grant (all zero when nothing requests)
//   gnt_idx    : binary grant index (0 when nothing requests)
//   any        : at least one request present
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             fixed,
  output logic [N_IN-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  int idx;

  // Walk the channels starting at ptr (or 0 in fixed mode), wrapping at
  // N_IN; the first requester found owns the grant.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = fixed ? k : (int'(ptr) + k) % N_IN;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < N_IN; i++) begin
      gnt_onehot[i] = any && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 stream multiplexer with round-robin / fixed-priority
// arbitration, multi-beat packet lock and a single registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_mux_rr_if.slave (producer inputs, consumer output,
//                debug view of lock FSM, rr_ptr and lock_ch)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_rr_if.slave  bus
);

  localparam int SEL_W = sel_w(N_IN);

  lock_state_t      state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0]  arb_gnt;
  logic [N_IN-1:0]  ready;
  logic             arb_any;
  logic             load;
  logic             accept;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    return (int'(g) == N_IN - 1) ? '0 : g + SEL_W'(1);
  endfunction

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (bus.in_valid),
    .ptr        (rr_ptr),
    .fixed      (bus.prio_mode == MODE_FIXED),
    .gnt_onehot (arb_gnt),
    .gnt_idx    (gnt_idx),
    .any        (arb_any)
  );

  // The output register can take a beat when empty or draining this cycle,
  // which gives pass-through with no bubble under continuous out_ready.
  // While locked the arbiter result is ignored and lock_ch is offered
  // ready regardless of its valid. rst_n gates ready so nothing appears
  // accepted while reset is held.
  always_comb begin
    load  = !bus.out_valid || bus.out_ready;
    sel   = (state == LOCKED) ? lock_ch : gnt_idx;
    ready = '0;
    if (rst_n && load) begin
      if (state == LOCKED) begin
        for (int i = 0; i < N_IN; i++) ready[i] = (lock_ch == SEL_W'(i));
      end else begin
        ready = arb_gnt;
      end
    end
    accept   = |(ready & bus.in_valid);
    sel_data = bus.in_data[int'(sel)*WIDTH +: WIDTH];
    sel_last = bus.in_last[sel];
  end

  assign bus.in_ready    = ready;
  assign bus.dbg_state   = state;
  assign bus.dbg_rr_ptr  = rr_ptr;
  assign bus.dbg_lock_ch = lock_ch;

  // Output register, rr_ptr and lock FSM. In LOCKED the pointer is only
  // moved by the closing beat, so a long packet does not skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_src   <= '0;
      rr_ptr        <= '0;
      lock_ch       <= '0;
      state         <= UNLOCKED;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= sel_data;
        bus.out_last  <= sel_last;
        bus.out_src   <= sel;
        if (state == UNLOCKED) begin
          if (!sel_last) begin
            state   <= LOCKED;
            lock_ch <= sel;
          end
          if (bus.prio_mode == MODE_RR) rr_ptr <= next_ptr(sel);
        end else if (sel_last) begin
          state <= UNLOCKED;
          if (bus.prio_mode == MODE_RR) rr_ptr <= next_ptr(lock_ch);
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int WIDTH = 32;
  localparam int N_IN  = 4;
  localparam int SEL_W = sel_w(N_IN);
  localparam int W     = SEL_W + 1 + WIDTH;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // scoreboard: {src, last, data} of every accepted beat, in order
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;

  // reference model state
  logic            m_valid;
  logic            m_locked;
  int              m_ptr;
  int              m_lock;
  logic            m_load;
  logic            m_found;
  int              m_g;
  int              m_c;
  logic [N_IN-1:0] m_ready;

  stream_mux_rr_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard monitor (negedge) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (bus.in_ready !== '0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_reset in_ready=%b out_valid=%b exp 0000/0", bus.in_ready, bus.out_valid);
      end
      m_valid = 1'b0; m_locked = 1'b0; m_ptr = 0; m_lock = 0;
      exp_q.delete();
    end else begin
      checks++;
      if (bus.out_valid !== m_valid) begin
        errors++;
        $display("FAIL sb_out_valid got %b exp %b", bus.out_valid, m_valid);
      end
      if (m_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty output beat with no expected entry");
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {bus.out_src, bus.out_last, bus.out_data};
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL sb_beat got %h exp %h", mon_got, mon_exp);
          end
        end
      end
      // next-edge prediction from the specified arbitration rules
      m_load  = !m_valid || bus.out_ready;
      m_found = 1'b0;
      m_g     = 0;
      if (m_locked) begin
        m_found = 1'b1;
        m_g     = m_lock;
      end else begin
        for (int k = 0; k < N_IN; k++) begin
          m_c = bus.prio_mode ? k : (m_ptr + k) % N_IN;
          if (!m_found && bus.in_valid[m_c]) begin
            m_found = 1'b1;
            m_g     = m_c;
          end
        end
      end
      m_ready = '0;
      if (m_load && m_found) m_ready[m_g] = 1'b1;
      checks++;
      if (bus.in_ready !== m_ready) begin
        errors++;
        $display("FAIL sb_in_ready got %b exp %b", bus.in_ready, m_ready);
      end
      if (m_ready[m_g] && bus.in_valid[m_g]) begin
        exp_q.push_back({SEL_W'(m_g), bus.in_last[m_g], bus.in_data[m_g*WIDTH +: WIDTH]});
        if (!m_locked) begin
          if (!bus.in_last[m_g]) begin
            m_locked = 1'b1;
            m_lock   = m_g;
          end
          if (bus.prio_mode == MODE_RR) m_ptr = (m_g + 1) % N_IN;
        end else if (bus.in_last[m_g]) begin
          m_locked = 1'b0;
          if (bus.prio_mode == MODE_RR) m_ptr = (m_lock + 1) % N_IN;
        end
        m_valid = 1'b1;
      end else if (m_load) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0;
    bus.in_last  = '0;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] data, input logic last);
    bus.in_data[ch*WIDTH +: WIDTH] = data;
    bus.in_last[ch]                = last;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.prio_mode = MODE_RR;
    bus.out_ready = 1'b1;
    bus.in_valid  = '1;
    bus.in_last   = '1;
    for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.out_src !== '0) begin errors++; $display("FAIL rst_out_src got %0d exp 0", bus.out_src); end
    checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", bus.in_ready); end
    checks++; if (bus.dbg_state !== UNLOCKED) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.dbg_state); end
    checks++; if (bus.dbg_rr_ptr !== '0) begin errors++; $display("FAIL rst_rr_ptr got %0d exp 0", bus.dbg_rr_ptr); end
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    bus.prio_mode = MODE_RR;
    bus.in_valid  = '1;
    for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid beat %0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_src !== SEL_W'(k % N_IN)) begin errors++; $display("FAIL rr_src beat %0d got %0d exp %0d", k, bus.out_src, k % N_IN); end
      for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'b1);
    end
    idle_inputs();
    checks++; if (bus.dbg_rr_ptr !== SEL_W'(1)) begin errors++; $display("FAIL rr_ptr_after got %0d exp 1", bus.dbg_rr_ptr); end
    step();
    step();
  endtask

  task automatic test_fixed_priority();
    bus.prio_mode = MODE_FIXED;
    bus.in_valid  = 4'b1010;
    for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL fix_in_ready cycle %0d got %b exp 0010", k, bus.in_ready); end
      step();
      checks++; if (bus.out_src !== SEL_W'(1)) begin errors++; $display("FAIL fix_src beat %0d got %0d exp 1", k, bus.out_src); end
      set_ch(1, $urandom(), 1'b1);
    end
    idle_inputs();
    bus.prio_mode = MODE_RR;
    checks++; if (bus.dbg_rr_ptr !== SEL_W'(1)) begin errors++; $display("FAIL fix_ptr_kept got %0d exp 1", bus.dbg_rr_ptr); end
    step();
    step();
  endtask

  task automatic test_packet_lock();
    // rr_ptr is 1 here; channel 2 is the only requester for the first beat
    bus.prio_mode = MODE_RR;
    bus.in_valid  = 4'b0100;
    set_ch(2, 32'hA000_0000, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_first_ready got %b exp 0100", bus.in_ready); end
    step();
    checks++; if (bus.out_src !== SEL_W'(2)) begin errors++; $display("FAIL lock_src0 got %0d exp 2", bus.out_src); end
    checks++; if (bus.dbg_state !== LOCKED) begin errors++; $display("FAIL lock_state got %0d exp 1", bus.dbg_state); end
    bus.in_valid = 4'b0111;
    set_ch(0, 32'h0000_0A0A, 1'b1);
    set_ch(1, 32'h0000_0B0B, 1'b1);
    set_ch(2, 32'hA000_0001, 1'b0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready beat %0d got %b exp 0100", k, bus.in_ready); end
      step();
      checks++; if (bus.out_src !== SEL_W'(2)) begin errors++; $display("FAIL lock_src beat %0d got %0d exp 2", k, bus.out_src); end
      set_ch(2, 32'hA000_0002, 1'b1);
    end
    checks++; if (bus.dbg_state !== UNLOCKED) begin errors++; $display("FAIL unlock_state got %0d exp 0", bus.dbg_state); end
    checks++; if (bus.dbg_rr_ptr !== SEL_W'(3)) begin errors++; $display("FAIL unlock_ptr got %0d exp 3", bus.dbg_rr_ptr); end
    bus.in_valid = 4'b0011;
    @(negedge clk);
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL after_lock_ready got %b exp 0001", bus.in_ready); end
    step();
    checks++; if (bus.out_src !== SEL_W'(0)) begin errors++; $display("FAIL after_lock_src got %0d exp 0", bus.out_src); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_backpressure();
    bus.in_valid = 4'b0010;
    set_ch(1, 32'hDEAD_BEEF, 1'b1);
    step();
    checks++; if (bus.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_load got %h exp deadbeef", bus.out_data); end
    bus.out_ready = 1'b0;
    set_ch(1, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp 0000", k, bus.in_ready); end
      checks++; if (bus.out_data !== 32'hDEAD_BEEF || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cycle %0d got %h/%b exp deadbeef/1", k, bus.out_data, bus.out_valid); end
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678) begin errors++; $display("FAIL bp_no_bubble got %b/%h exp 1/12345678", bus.out_valid, bus.out_data); end
    idle_inputs();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_wrap_reset();
    // rr_ptr is 2 here: one beat from channel 2 moves it to 3
    bus.in_valid = 4'b0100;
    set_ch(2, $urandom(), 1'b1);
    step();
    checks++; if (bus.out_src !== SEL_W'(2)) begin errors++; $display("FAIL wrap_pre_src got %0d exp 2", bus.out_src); end
    bus.in_valid = 4'b1111;
    for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'b1);
    step();
    checks++; if (bus.out_src !== SEL_W'(3)) begin errors++; $display("FAIL wrap_src3 got %0d exp 3", bus.out_src); end
    checks++; if (bus.dbg_rr_ptr !== '0) begin errors++; $display("FAIL wrap_ptr got %0d exp 0", bus.dbg_rr_ptr); end
    step();
    checks++; if (bus.out_src !== SEL_W'(0)) begin errors++; $display("FAIL wrap_src0 got %0d exp 0", bus.out_src); end
    bus.in_valid = 4'b0010;
    set_ch(1, 32'hC0DE_0001, 1'b0);
    step();
    checks++; if (bus.dbg_state !== LOCKED) begin errors++; $display("FAIL rst_mid_locked got %0d exp 1", bus.dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL rst_mid_ready got %b exp 0000", bus.in_ready); end
    checks++; if (bus.dbg_state !== UNLOCKED) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", bus.dbg_state); end
    step();
    rst_n        = 1'b1;
    bus.in_valid = 4'b1010;
    set_ch(1, $urandom(), 1'b1);
    set_ch(3, $urandom(), 1'b1);
    step();
    checks++; if (bus.out_src !== SEL_W'(1)) begin errors++; $display("FAIL post_rst_src got %0d exp 1", bus.out_src); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      bus.in_valid  = N_IN'($urandom_range(0, (1 << N_IN) - 1));
      for (int i = 0; i < N_IN; i++) set_ch(i, $urandom(), 1'($urandom_range(0, 2) != 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.prio_mode = ~bus.prio_mode;
      step();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.prio_mode = MODE_RR;
    repeat (3) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_packet_lock();
    test_backpressure();
    test_wrap_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
